// File: rtl/id_decode_stage_hs_pkg.sv
// Shared opcode/instruction-set codes and field helpers for the handshaked decode stage.
package id_decode_stage_hs_pkg;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_SW  = 4'h1;
    localparam logic [3:0] OPC_PFX = 4'h2;
    localparam logic [3:0] OPC_LI  = 4'h3;
    localparam logic [3:0] OPC_LIS = 4'h4;
    localparam logic [3:0] OPC_ADD = 4'h5;
    localparam logic [3:0] OPC_SUB = 4'h6;
    localparam logic [3:0] OPC_AND = 4'h7;
    localparam logic [3:0] OPC_OR  = 4'h8;
    localparam logic [3:0] OPC_CMP = 4'h9;
    localparam logic [3:0] OPC_MOV = 4'hA;
    localparam logic [3:0] OPC_LD  = 4'hB;
    localparam logic [3:0] OPC_ST  = 4'hC;
    localparam logic [3:0] OPC_BCC = 4'hD;
    localparam logic [3:0] OPC_JMP = 4'hE;
    localparam logic [3:0] OPC_OUT = 4'hF;

    localparam logic [3:0] ISET_R  = 4'h0;
    localparam logic [3:0] ISET_RS = 4'h1;
    localparam logic [3:0] ISET_I  = 4'h2;
    localparam logic [3:0] ISET_IS = 4'h3;
    localparam logic [3:0] ISET_S  = 4'h4;

    function automatic logic reg_tgt_read_fn(input logic [3:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) ||
               (opc == OPC_OR)  || (opc == OPC_CMP) || (opc == OPC_ST);
    endfunction

    function automatic logic reg_src_read_fn(input logic [3:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) ||
               (opc == OPC_OR)  || (opc == OPC_CMP) || (opc == OPC_MOV) ||
               (opc == OPC_LD)  || (opc == OPC_ST)  || (opc == OPC_OUT);
    endfunction

    // Packed width of the decoded entry: pc, instr, iset, five reg fields, imm_en, imm_hilo, imm_val, off, sgn_en
    function automatic int unsigned entry_w(input int unsigned dw, input int unsigned rw,
                                            input int unsigned iw);
        return 2*dw + 4 + 5*rw + 2 + 2*iw + iw + 1;
    endfunction

endpackage

// File: rtl/id_decode_stage_hs_if.sv
// Upstream (fetch) and downstream (execute) handshake bundle of the decode stage.
interface id_decode_stage_hs_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned IMM_W  = 6
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    pc_in;
    logic [DATA_W-1:0]    instr_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    pc_out;
    logic [DATA_W-1:0]    instr_out;
    logic [3:0]           instr_set_out;
    logic [REG_W-1:0]     bcc_out;
    logic [REG_W-1:0]     tgt_gp_out;
    logic [REG_W-1:0]     tgt_sr_out;
    logic [REG_W-1:0]     src_gp_out;
    logic [REG_W-1:0]     src_sr_out;
    logic                 imm_en_out;
    logic                 imm_hilo_out;
    logic [2*IMM_W-1:0]   imm_val_out;
    logic [IMM_W-1:0]     off_out;
    logic                 sgn_en_out;

    modport master (
        output in_valid, pc_in, instr_in, out_ready,
        input  in_ready, out_valid, pc_out, instr_out, instr_set_out, bcc_out,
               tgt_gp_out, tgt_sr_out, src_gp_out, src_sr_out, imm_en_out,
               imm_hilo_out, imm_val_out, off_out, sgn_en_out
    );

    modport slave (
        input  in_valid, pc_in, instr_in, out_ready,
        output in_ready, out_valid, pc_out, instr_out, instr_set_out, bcc_out,
               tgt_gp_out, tgt_sr_out, src_gp_out, src_sr_out, imm_en_out,
               imm_hilo_out, imm_val_out, off_out, sgn_en_out
    );
endinterface

// File: rtl/id_skid_buffer.sv
// Two-entry valid/ready FIFO; head is ent0_q and stays stable until popped.
module id_skid_buffer #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [W-1:0]  dout_o
);
    logic [1:0]   count_q, count_d;
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: if (push_i) begin
                    ent0_d  = din_i;
                    count_d = 2'd1;
                end
                2'd1: if (push_i && pop_i) begin
                    ent0_d = din_i;
                end else if (push_i) begin
                    ent1_d  = din_i;
                    count_d = 2'd2;
                end else if (pop_i) begin
                    count_d = 2'd0;
                end
                2'd2: if (pop_i) begin
                    ent0_d  = ent1_q;
                    count_d = 2'd1;
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ent0_q  <= RST_VAL;
            ent1_q  <= RST_VAL;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign ready_o = (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign dout_o  = ent0_q;
endmodule

// File: rtl/id_decode_stage_hs.sv
// Instruction-decode stage: combinational field decode, SW/PFX handling and a 2-entry skid buffer.
module id_decode_stage_hs
    import id_decode_stage_hs_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned OPC_W      = 4,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned IMM_W      = 6,
    parameter bit          PFX_EN     = 1'b1,
    parameter logic [3:0]  ISET_RESET = ISET_R
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_in,
    input  logic [3:0]  iset_restore_in,
    output logic [3:0]  iset_cur_out,
    id_decode_stage_hs_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  instr;
        logic [3:0]         iset;
        logic [REG_W-1:0]   bcc;
        logic [REG_W-1:0]   tgt_gp;
        logic [REG_W-1:0]   tgt_sr;
        logic [REG_W-1:0]   src_gp;
        logic [REG_W-1:0]   src_sr;
        logic               imm_en;
        logic               imm_hilo;
        logic [2*IMM_W-1:0] imm_val;
        logic [IMM_W-1:0]   off;
        logic               sgn_en;
    } entry_t;

    localparam int unsigned ENTRY_W = entry_w(DATA_W, REG_W, IMM_W);
    // Only the iset field of the head entry is non-zero out of reset
    localparam logic [ENTRY_W-1:0] ENTRY_RST =
        {{(2*DATA_W){1'b0}}, ISET_RESET, {(ENTRY_W-2*DATA_W-4){1'b0}}};

    logic [3:0]        iset_q, iset_d;
    logic [IMM_W-1:0]  pfx_q, pfx_d;
    logic              pend_q, pend_d;
    logic [3:0]        opc4;
    logic              is_sw, is_pfx, is_nop, is_li;
    logic              buf_ready, accept, push, pop;
    entry_t            ent_d, ent_q;
    logic [ENTRY_W-1:0] buf_dout;

    assign opc4   = 4'(bus.instr_in[DATA_W-1 -: OPC_W]);
    assign is_sw  = (opc4 == OPC_SW);
    assign is_pfx = PFX_EN && (opc4 == OPC_PFX);
    assign is_nop = (opc4 == OPC_NOP);
    assign is_li  = (opc4 == OPC_LI) || (opc4 == OPC_LIS);

    assign bus.in_ready = buf_ready && !flush_in;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && !is_sw && !is_pfx && !is_nop;
    assign pop          = bus.out_valid && bus.out_ready && !flush_in;

    always_comb begin
        ent_d          = '0;
        ent_d.pc       = bus.pc_in;
        ent_d.instr    = bus.instr_in;
        ent_d.iset     = iset_q;
        ent_d.bcc      = REG_W'(bus.instr_in[7:4]);
        ent_d.off      = bus.instr_in[IMM_W-1:0];
        ent_d.imm_hilo = bus.instr_in[7];
        if (iset_q == ISET_S) begin
            ent_d.tgt_sr = REG_W'(bus.instr_in[7:4]);
            ent_d.src_sr = REG_W'(bus.instr_in[3:0]);
        end else begin
            ent_d.tgt_gp = reg_tgt_read_fn(opc4) ? REG_W'(bus.instr_in[7:4]) : '0;
            ent_d.src_gp = reg_src_read_fn(opc4) ? REG_W'(bus.instr_in[3:0]) : '0;
        end
        ent_d.sgn_en = (iset_q == ISET_RS) || (iset_q == ISET_IS);
        ent_d.imm_en = ((iset_q == ISET_I) || (iset_q == ISET_IS)) && !is_li;
        if (pend_q && (ent_d.imm_en || is_li))
            ent_d.imm_val = {pfx_q, bus.instr_in[IMM_W-1:0]};
        else if (ent_d.sgn_en)
            ent_d.imm_val = {{IMM_W{bus.instr_in[IMM_W-1]}}, bus.instr_in[IMM_W-1:0]};
        else
            ent_d.imm_val = {{IMM_W{1'b0}}, bus.instr_in[IMM_W-1:0]};
    end

    // Any pushed word ends the prefix window, whether or not it used the prefix
    always_comb begin
        iset_d = iset_q;
        pfx_d  = pfx_q;
        pend_d = pend_q;
        if (flush_in) begin
            iset_d = iset_restore_in;
            pend_d = 1'b0;
        end else if (accept && is_sw) begin
            iset_d = {1'b0, bus.instr_in[2:0]};
        end else if (accept && is_pfx) begin
            pfx_d  = bus.instr_in[IMM_W-1:0];
            pend_d = 1'b1;
        end else if (push) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iset_q <= ISET_RESET;
            pfx_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            iset_q <= iset_d;
            pfx_q  <= pfx_d;
            pend_q <= pend_d;
        end
    end

    id_skid_buffer #(.W(ENTRY_W), .RST_VAL(ENTRY_RST)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_in),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ent_d),
        .ready_o (buf_ready),
        .valid_o (bus.out_valid),
        .dout_o  (buf_dout)
    );

    assign ent_q             = entry_t'(buf_dout);
    assign bus.pc_out        = ent_q.pc;
    assign bus.instr_out     = ent_q.instr;
    assign bus.instr_set_out = ent_q.iset;
    assign bus.bcc_out       = ent_q.bcc;
    assign bus.tgt_gp_out    = ent_q.tgt_gp;
    assign bus.tgt_sr_out    = ent_q.tgt_sr;
    assign bus.src_gp_out    = ent_q.src_gp;
    assign bus.src_sr_out    = ent_q.src_sr;
    assign bus.imm_en_out    = ent_q.imm_en;
    assign bus.imm_hilo_out  = ent_q.imm_hilo;
    assign bus.imm_val_out   = ent_q.imm_val;
    assign bus.off_out       = ent_q.off;
    assign bus.sgn_en_out    = ent_q.sgn_en;
    assign iset_cur_out      = iset_q;
endmodule

// File: tb/tb_id_decode_stage_hs.sv
// Directed bench for id_decode_stage_hs: decode fields, SW/PFX, backpressure, flush and async reset.
module tb_id_decode_stage_hs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush_in = 1'b0;
    logic [3:0] iset_restore_in = 4'h0;
    logic [3:0] iset_cur_out;
    int         vectors = 0;
    int         miscompares = 0;

    id_decode_stage_hs_if #(.DATA_W(12), .REG_W(4), .IMM_W(6)) bus ();

    id_decode_stage_hs dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_in        (flush_in),
        .iset_restore_in (iset_restore_in),
        .iset_cur_out    (iset_cur_out),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [11:0] pc, input logic [11:0] ins);
        bus.in_valid = 1'b1;
        bus.pc_in    = pc;
        bus.instr_in = ins;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.pc_in = '0; bus.instr_in = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %0h want 0", bus.out_valid); end
        vectors++; if (iset_cur_out !== 4'h0) begin miscompares++; $display("FAIL rst_iset_cur got %0h want 0", iset_cur_out); end
        vectors++; if (bus.imm_val_out !== 12'h000) begin miscompares++; $display("FAIL rst_imm_val got %0h want 0", bus.imm_val_out); end
        vectors++; if (bus.pc_out !== 12'h000) begin miscompares++; $display("FAIL rst_pc got %0h want 0", bus.pc_out); end
        rst_n = 1'b1;
        cyc();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %0h want 1", bus.in_ready); end
        vectors++; if (bus.instr_set_out !== 4'h0) begin miscompares++; $display("FAIL rst_instr_set got %0h want 0", bus.instr_set_out); end
    endtask

    task automatic test_reg_op();
        bus.out_ready = 1'b1;
        put(12'h100, 12'h5C0);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL reg_valid got %0h want 1", bus.out_valid); end
        vectors++; if (bus.pc_out !== 12'h100) begin miscompares++; $display("FAIL reg_pc got %0h want 100", bus.pc_out); end
        vectors++; if (bus.tgt_gp_out !== 4'hC) begin miscompares++; $display("FAIL reg_tgt_gp got %0h want c", bus.tgt_gp_out); end
        vectors++; if (bus.instr_set_out !== 4'h0) begin miscompares++; $display("FAIL reg_iset got %0h want 0", bus.instr_set_out); end
        vectors++; if (bus.imm_val_out !== 12'h000) begin miscompares++; $display("FAIL reg_imm_val got %0h want 0", bus.imm_val_out); end
        vectors++; if (bus.imm_en_out !== 1'b0) begin miscompares++; $display("FAIL reg_imm_en got %0h want 0", bus.imm_en_out); end
        put(12'h101, 12'hA79);
        vectors++; if (bus.pc_out !== 12'h101) begin miscompares++; $display("FAIL mov_pc got %0h want 101", bus.pc_out); end
        vectors++; if (bus.tgt_gp_out !== 4'h0) begin miscompares++; $display("FAIL mov_tgt_gp got %0h want 0", bus.tgt_gp_out); end
        vectors++; if (bus.src_gp_out !== 4'h9) begin miscompares++; $display("FAIL mov_src_gp got %0h want 9", bus.src_gp_out); end
        cyc();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reg_drain got %0h want 0", bus.out_valid); end
    endtask

    task automatic test_sw();
        put(12'h102, 12'h102);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL sw_no_push got %0h want 0", bus.out_valid); end
        vectors++; if (iset_cur_out !== 4'h2) begin miscompares++; $display("FAIL sw_iset got %0h want 2", iset_cur_out); end
        put(12'h103, 12'h53F);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL seti_valid got %0h want 1", bus.out_valid); end
        vectors++; if (bus.imm_en_out !== 1'b1) begin miscompares++; $display("FAIL seti_imm_en got %0h want 1", bus.imm_en_out); end
        vectors++; if (bus.imm_val_out !== 12'h03F) begin miscompares++; $display("FAIL seti_imm_val got %0h want 03f", bus.imm_val_out); end
        vectors++; if (bus.instr_set_out !== 4'h2) begin miscompares++; $display("FAIL seti_iset got %0h want 2", bus.instr_set_out); end
        vectors++; if (bus.sgn_en_out !== 1'b0) begin miscompares++; $display("FAIL seti_sgn got %0h want 0", bus.sgn_en_out); end
    endtask

    task automatic test_pfx();
        put(12'h110, 12'h215);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL pfx_no_push got %0h want 0", bus.out_valid); end
        put(12'h111, 12'h52A);
        vectors++; if (bus.imm_val_out !== 12'h56A) begin miscompares++; $display("FAIL pfx_imm got %0h want 56a", bus.imm_val_out); end
        put(12'h112, 12'h52A);
        vectors++; if (bus.imm_val_out !== 12'h02A) begin miscompares++; $display("FAIL pfx_cleared got %0h want 02a", bus.imm_val_out); end
        put(12'h113, 12'h203);
        put(12'h114, 12'h0FF);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL nop_no_push got %0h want 0", bus.out_valid); end
        put(12'h115, 12'h501);
        vectors++; if (bus.imm_val_out !== 12'h0C1) begin miscompares++; $display("FAIL nop_keeps_pfx got %0h want 0c1", bus.imm_val_out); end
        put(12'h116, 12'h203);
        put(12'h117, 12'h207);
        put(12'h118, 12'h500);
        vectors++; if (bus.imm_val_out !== 12'h1C0) begin miscompares++; $display("FAIL pfx_overwrite got %0h want 1c0", bus.imm_val_out); end
        put(12'h119, 12'h201);
        put(12'h11A, 12'h305);
        vectors++; if (bus.imm_val_out !== 12'h045) begin miscompares++; $display("FAIL li_pfx got %0h want 045", bus.imm_val_out); end
        vectors++; if (bus.imm_en_out !== 1'b0) begin miscompares++; $display("FAIL li_imm_en got %0h want 0", bus.imm_en_out); end
    endtask

    task automatic test_signed();
        put(12'h120, 12'h103);
        vectors++; if (iset_cur_out !== 4'h3) begin miscompares++; $display("FAIL sw_is got %0h want 3", iset_cur_out); end
        put(12'h121, 12'h520);
        vectors++; if (bus.sgn_en_out !== 1'b1) begin miscompares++; $display("FAIL is_sgn got %0h want 1", bus.sgn_en_out); end
        vectors++; if (bus.imm_val_out !== 12'hFE0) begin miscompares++; $display("FAIL is_imm got %0h want fe0", bus.imm_val_out); end
        put(12'h122, 12'h41F);
        vectors++; if (bus.imm_val_out !== 12'h01F) begin miscompares++; $display("FAIL lis_imm got %0h want 01f", bus.imm_val_out); end
        vectors++; if (bus.imm_en_out !== 1'b0) begin miscompares++; $display("FAIL lis_imm_en got %0h want 0", bus.imm_en_out); end
    endtask

    task automatic test_iset_s();
        put(12'h130, 12'h104);
        put(12'h131, 12'h5A5);
        vectors++; if (bus.tgt_sr_out !== 4'hA) begin miscompares++; $display("FAIL s_tgt_sr got %0h want a", bus.tgt_sr_out); end
        vectors++; if (bus.src_sr_out !== 4'h5) begin miscompares++; $display("FAIL s_src_sr got %0h want 5", bus.src_sr_out); end
        vectors++; if (bus.tgt_gp_out !== 4'h0) begin miscompares++; $display("FAIL s_tgt_gp got %0h want 0", bus.tgt_gp_out); end
        vectors++; if (bus.src_gp_out !== 4'h0) begin miscompares++; $display("FAIL s_src_gp got %0h want 0", bus.src_gp_out); end
        vectors++; if (bus.bcc_out !== 4'hA) begin miscompares++; $display("FAIL s_bcc got %0h want a", bus.bcc_out); end
        vectors++; if (bus.off_out !== 6'h25) begin miscompares++; $display("FAIL s_off got %0h want 25", bus.off_out); end
        vectors++; if (bus.imm_hilo_out !== 1'b1) begin miscompares++; $display("FAIL s_hilo got %0h want 1", bus.imm_hilo_out); end
        vectors++; if (bus.instr_set_out !== 4'h4) begin miscompares++; $display("FAIL s_iset got %0h want 4", bus.instr_set_out); end
    endtask

    task automatic test_back_to_back();
        put(12'h140, 12'h100);
        cyc();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.pc_in = 12'h200; bus.instr_in = 12'hA01;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready0 got %0h want 1", bus.in_ready); end
        cyc();
        bus.pc_in = 12'h201; bus.instr_in = 12'hA02;
        cyc();
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got %0h want 0", bus.in_ready); end
        bus.pc_in = 12'h202; bus.instr_in = 12'hA03;
        cyc();
        cyc();
        vectors++; if (bus.pc_out !== 12'h200) begin miscompares++; $display("FAIL bp_hold got %0h want 200", bus.pc_out); end
        vectors++; if (bus.src_gp_out !== 4'h1) begin miscompares++; $display("FAIL bp_hold_src got %0h want 1", bus.src_gp_out); end
        bus.out_ready = 1'b1;
        cyc();
        vectors++; if (bus.pc_out !== 12'h201) begin miscompares++; $display("FAIL bp_second got %0h want 201", bus.pc_out); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_reopen got %0h want 1", bus.in_ready); end
        cyc();
        bus.in_valid = 1'b0;
        vectors++; if (bus.pc_out !== 12'h202) begin miscompares++; $display("FAIL bp_third got %0h want 202", bus.pc_out); end
        vectors++; if (bus.src_gp_out !== 4'h3) begin miscompares++; $display("FAIL bp_third_src got %0h want 3", bus.src_gp_out); end
        cyc();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %0h want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        put(12'h300, 12'hA04);
        put(12'h301, 12'hA05);
        bus.in_valid = 1'b1; bus.pc_in = 12'h302; bus.instr_in = 12'h101;
        flush_in = 1'b1; iset_restore_in = 4'h4;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_ready got %0h want 0", bus.in_ready); end
        cyc();
        flush_in = 1'b0; bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_empty got %0h want 0", bus.out_valid); end
        vectors++; if (iset_cur_out !== 4'h4) begin miscompares++; $display("FAIL fl_iset got %0h want 4", iset_cur_out); end
        bus.out_ready = 1'b1;
        put(12'h303, 12'h102);
        put(12'h304, 12'h215);
        bus.in_valid = 1'b1; bus.pc_in = 12'h305; bus.instr_in = 12'h52A;
        flush_in = 1'b1; iset_restore_in = 4'h2;
        cyc();
        flush_in = 1'b0; bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_no_accept got %0h want 0", bus.out_valid); end
        vectors++; if (iset_cur_out !== 4'h2) begin miscompares++; $display("FAIL fl_restore got %0h want 2", iset_cur_out); end
        put(12'h306, 12'h52A);
        vectors++; if (bus.imm_val_out !== 12'h02A) begin miscompares++; $display("FAIL fl_pfx_drop got %0h want 02a", bus.imm_val_out); end
        vectors++; if (bus.pc_out !== 12'h306) begin miscompares++; $display("FAIL fl_next_pc got %0h want 306", bus.pc_out); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        put(12'h400, 12'hA05);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre got %0h want 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %0h want 0", bus.out_valid); end
        vectors++; if (iset_cur_out !== 4'h0) begin miscompares++; $display("FAIL ar_iset got %0h want 0", iset_cur_out); end
        vectors++; if (bus.pc_out !== 12'h000) begin miscompares++; $display("FAIL ar_pc got %0h want 0", bus.pc_out); end
        #1 rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_reg_op();
        test_sw();
        test_pfx();
        test_signed();
        test_iset_s();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
